// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register file: FSM encoding,
// command-byte field positions and the reserved-bit decode helper.
package spi_pkg;

    localparam int BYTE_W     = 8;
    localparam int CMD_RW_BIT = 7;
    localparam logic RW_READ  = 1'b1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RDATA = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // True when any bit between the address field and the RW bit is set.
    function automatic logic cmd_rsvd_set(input logic [BYTE_W-1:0] cmd, input int addr_w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < CMD_RW_BIT; i++) begin
            if (i >= addr_w && cmd[i]) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave fronting a byte-wide register file. Define
// SPI_SLAVE_AUTOINC_EN to advance the address after every data byte.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter int          ADDR_W      = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              SPI_SCLK,
    input  logic              SPI_CSN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              busy,
    output logic              reg_wr_pulse,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data,
    output logic              cmd_err
);

    logic sclk_rise, sclk_fall, csn_rise, csn_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .din   (SPI_SCLK),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // CSN resets to "low" so a frame already running at reset release
    // never produces a fall; a new frame needs CSN seen high first.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csn_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .din   (SPI_CSN),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    logic [2:0]          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                miso_q, miso_d;
    logic                wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
    logic                cmd_err_q, cmd_err_d;
    logic [BYTE_W-1:0]   regs_q [DEPTH];
    logic [BYTE_W-1:0]   regs_d [DEPTH];

    logic [BYTE_W-1:0]   rx_byte;
    logic [ADDR_W-1:0]   addr_next;

    assign rx_byte = {shift_q, mosi_s};

`ifdef SPI_SLAVE_AUTOINC_EN
    assign addr_next = addr_q + 1'b1;
`else
    assign addr_next = addr_q;
`endif

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        miso_d     = 1'b0;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cmd_err_d  = 1'b0;
        regs_d     = regs_q;

        case (state_q)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    shift_d   = rx_byte[BYTE_W-2:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = rx_byte[ADDR_W-1:0];
                        if (cmd_rsvd_set(rx_byte, ADDR_W)) begin
                            state_d   = ST_ERR;
                            cmd_err_d = 1'b1;
                        end else if (rx_byte[CMD_RW_BIT] == RW_READ) begin
                            state_d = ST_RDATA;
                            tx_d    = regs_q[rx_byte[ADDR_W-1:0]];
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (sclk_rise) begin
                    shift_d   = rx_byte[BYTE_W-2:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        regs_d[addr_q] = rx_byte;
                        wr_pulse_d     = 1'b1;
                        wr_addr_d      = addr_q;
                        wr_data_d      = rx_byte;
                        addr_d         = addr_next;
                    end
                end
            end
            ST_RDATA: begin
                miso_d = miso_q;
                if (sclk_fall) begin
                    miso_d = tx_q[BYTE_W-1];
                    tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
                end
                // Reload on the 8th rise so the following fall presents bit7.
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = addr_next;
                        tx_d   = regs_q[addr_next];
                    end
                end
            end
            ST_ERR: begin
                miso_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over the state update but not over a just-committed write.
        if (csn_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end
    end

    // NOTE: the register file is built from flops, so each entry is reset to
    // RESET_VAL; a RAM macro could not offer that reset value.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cmd_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cmd_err_q   <= cmd_err_d;
            regs_q      <= regs_d;
        end
    end

    assign SPI_MISO     = miso_q;
    assign busy         = (state_q != ST_IDLE);
    assign reg_wr_pulse = wr_pulse_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign cmd_err      = cmd_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: drives mode-0 SPI frames and
// checks write strobes, read-back data, error pulses, abort and reset.
module tb_spi_slave_regfile;

    localparam int HALF = 80;

    logic       sclk     = 1'b0;
    logic       rst_n    = 1'b0;
    logic       SPI_SCLK = 1'b0;
    logic       SPI_CSN  = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic       busy;
    logic       reg_wr_pulse;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       cmd_err;

    spi_slave_regfile #(
        .DEPTH       (16),
        .ADDR_W      (4),
        .SYNC_STAGES (2),
        .RESET_VAL   (8'h00)
    ) dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .SPI_SCLK     (SPI_SCLK),
        .SPI_CSN      (SPI_CSN),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_MISO     (SPI_MISO),
        .busy         (busy),
        .reg_wr_pulse (reg_wr_pulse),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .cmd_err      (cmd_err)
    );

    always #5 sclk = ~sclk;

    int tests = 0;
    int fails = 0;

    // Strobe monitor, sampled on the inactive edge.
    int         pulse_cnt = 0;
    int         err_cnt   = 0;
    logic [3:0] pulse_addr [64];
    logic [7:0] pulse_data [64];

    always @(negedge sclk) begin
        if (reg_wr_pulse && pulse_cnt < 64) begin
            pulse_addr[pulse_cnt] = reg_wr_addr;
            pulse_data[pulse_cnt] = reg_wr_data;
            pulse_cnt = pulse_cnt + 1;
        end
        if (cmd_err) err_cnt = err_cnt + 1;
    end

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    logic       busy_mid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            SPI_MOSI = tx[7-k];
            #HALF;
            SPI_SCLK = 1'b1;
            rx[7-k] = SPI_MISO;
            #HALF;
            SPI_SCLK = 1'b0;
        end
    endtask

    task automatic frame(input int nbytes, input int last_bits);
        logic [7:0] r;
        SPI_CSN = 1'b0;
        #HALF;
        for (int b = 0; b < nbytes; b++) begin
            send_byte(tx_buf[b], (b == nbytes - 1) ? last_bits : 8, r);
            rx_buf[b] = r;
            if (b == 0) busy_mid = busy;
        end
        #HALF;
        SPI_CSN = 1'b1;
        #(4 * HALF);
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        tx_buf[0] = {4'h0, a};
        tx_buf[1] = d;
        frame(2, 8);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        tx_buf[0] = {4'h8, a};
        tx_buf[1] = 8'h00;
        frame(2, 8);
        d = rx_buf[1];
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] wdata;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [7:0] rd;
        int         pc;
        int         ec;

        vecs[0] = '{cmd: 8'h01, wdata: 8'h5A, exp_addr: 4'h1, exp_data: 8'h5A, exp_rd: 8'h5A};
        vecs[1] = '{cmd: 8'h07, wdata: 8'hFF, exp_addr: 4'h7, exp_data: 8'hFF, exp_rd: 8'hFF};
        vecs[2] = '{cmd: 8'h08, wdata: 8'h01, exp_addr: 4'h8, exp_data: 8'h01, exp_rd: 8'h01};
        vecs[3] = '{cmd: 8'h0E, wdata: 8'h80, exp_addr: 4'hE, exp_data: 8'h80, exp_rd: 8'h80};

        // Reset and idle bus.
        repeat (3) @(posedge sclk);
        #1;
        check("rst busy", busy, 0);
        check("rst miso", SPI_MISO, 0);
        check("rst pulse", reg_wr_pulse, 0);
        check("rst wr_addr", reg_wr_addr, 0);
        check("rst wr_data", reg_wr_data, 0);
        check("rst cmd_err", cmd_err, 0);
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (4) @(negedge sclk);
        read_reg(4'h3, rd);
        check("reset val reg3", rd, 8'h00);
        check("no pulse on read", pulse_cnt, 0);

        // Two-byte write burst from address 2, then read back.
        pc = pulse_cnt;
        tx_buf[0] = 8'h02; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h3C;
        frame(3, 8);
        check("busy in frame", busy_mid, 1);
        check("burst pulse count", pulse_cnt - pc, 2);
        check("burst p0 addr", pulse_addr[pc], 4'h2);
        check("burst p0 data", pulse_data[pc], 8'hA5);
`ifdef SPI_SLAVE_AUTOINC_EN
        check("burst p1 addr", pulse_addr[pc+1], 4'h3);
`else
        check("burst p1 addr", pulse_addr[pc+1], 4'h2);
`endif
        check("burst p1 data", pulse_data[pc+1], 8'h3C);
        tx_buf[0] = 8'h82; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        frame(3, 8);
        check("miso during cmd", rx_buf[0], 8'h00);
`ifdef SPI_SLAVE_AUTOINC_EN
        check("burst rd0", rx_buf[1], 8'hA5);
`else
        check("burst rd0", rx_buf[1], 8'h3C);
`endif
        check("burst rd1", rx_buf[2], 8'h3C);

        // Table of single-byte write/read-back vectors.
        for (int i = 0; i < 4; i++) begin
            pc = pulse_cnt;
            write_reg(vecs[i].cmd[3:0], vecs[i].wdata);
            check("vec pulse count", pulse_cnt - pc, 1);
            check("vec pulse addr", pulse_addr[pc], vecs[i].exp_addr);
            check("vec pulse data", pulse_data[pc], vecs[i].exp_data);
            read_reg(vecs[i].cmd[3:0], rd);
            check("vec readback", rd, vecs[i].exp_rd);
        end

        // Burst from the top address wraps to 0 with auto-increment.
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
        frame(3, 8);
        read_reg(4'hF, rd);
`ifdef SPI_SLAVE_AUTOINC_EN
        check("wrap reg15", rd, 8'h11);
        read_reg(4'h0, rd);
        check("wrap reg0", rd, 8'h22);
`else
        check("wrap reg15", rd, 8'h22);
        read_reg(4'h0, rd);
        check("wrap reg0", rd, 8'h00);
`endif

        // Reserved command bit set: error pulse, no write, MISO low.
        pc = pulse_cnt;
        ec = err_cnt;
        tx_buf[0] = 8'h40; tx_buf[1] = 8'hFF;
        frame(2, 8);
        check("err pulse count", err_cnt - ec, 1);
        check("err no write", pulse_cnt - pc, 0);
        check("err miso", rx_buf[1], 8'h00);
        read_reg(4'h0, rd);
`ifdef SPI_SLAVE_AUTOINC_EN
        check("err reg0 kept", rd, 8'h22);
`else
        check("err reg0 kept", rd, 8'h00);
`endif

        // CSN raised after 5 data bits discards the byte.
        pc = pulse_cnt;
        tx_buf[0] = 8'h05; tx_buf[1] = 8'hC3;
        frame(2, 5);
        check("abort no pulse", pulse_cnt - pc, 0);
        read_reg(4'h5, rd);
        check("abort reg5 kept", rd, 8'h00);
        pc = pulse_cnt;
        write_reg(4'h5, 8'h77);
        check("post-abort pulse", pulse_cnt - pc, 1);
        read_reg(4'h5, rd);
        check("post-abort reg5", rd, 8'h77);

        // Reset mid read frame; remaining edges must be ignored.
        SPI_CSN = 1'b0;
        #HALF;
        send_byte(8'h82, 8, rd);
        send_byte(8'h00, 3, rd);
        rst_n = 1'b0;
        @(posedge sclk);
        #1;
        check("midrst busy", busy, 0);
        check("midrst miso", SPI_MISO, 0);
        check("midrst wr_addr", reg_wr_addr, 0);
        check("midrst wr_data", reg_wr_data, 0);
        @(negedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        pc = pulse_cnt;
        send_byte(8'h00, 5, rd);
        send_byte(8'h3C, 8, rd);
        check("midrst ignored miso", rd, 8'h00);
        check("midrst ignored busy", busy, 0);
        #HALF;
        SPI_CSN = 1'b1;
        #(4 * HALF);
        check("midrst no pulse", pulse_cnt - pc, 0);
        read_reg(4'h2, rd);
        check("midrst reg2 reset", rd, 8'h00);
        write_reg(4'h6, 8'h99);
        read_reg(4'h6, rd);
        check("midrst next frame", rd, 8'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI mode-0 slave with an internal byte-wide register file; it is the far-end device on the SPI_SCLK / SPI_CSN / SPI_MOSI / SPI_MISO bus driven by the SPI master.
- Oversamples the SPI pins in the system clock domain and decodes a command byte followed by a data burst.
- Writes update the register file; reads return register contents on SPI_MISO.
- Serves as a synthesizable bus partner for the master's directed and loop-back tests, and as a local config block.

Parameters:
- DEPTH, 16, number of 8-bit registers; power of two, 2..128.
- ADDR_W, 4, log2(DEPTH).
- SYNC_STAGES, 2, synchronizer flops per SPI input; 2 or 3.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- SPI_SCLK  in  1  SPI clock from master; idle low (mode 0).
- SPI_CSN  in  1  chip select, active low.
- SPI_MOSI  in  1  master-out data, MSB first.
- SPI_MISO  out  1  slave-out data, MSB first.
- busy  out  1  high while a frame is active (synchronized CSN low).
- reg_wr_pulse  out  1  one-cycle strobe per committed write byte.
- reg_wr_addr  out  ADDR_W  address of the committed write.
- reg_wr_data  out  8  data of the committed write.
- cmd_err  out  1  one-cycle pulse on an illegal command byte.

Behaviour:
- Clocking/reset:
  - Single clock, sclk.
  - Reset is synchronous, active-low rst_n.
  - On reset: SPI_MISO=0, busy=0, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0, cmd_err=0, every register = RESET_VAL, state=IDLE.
- Input conditioning:
  - SPI_SCLK, SPI_CSN and SPI_MOSI each pass through SYNC_STAGES flops.
  - Rise/fall detect on the synchronized SPI_SCLK; detect-to-action latency is SYNC_STAGES+1 sclk cycles.
  - Timing requirement: sclk frequency >= 8x SPI_SCLK frequency (master sclk_divider >= 4). Behaviour is undefined below this.
- Frame format:
  - Byte 0 is the command: bit7 RW (1=read, 0=write), bits[ADDR_W-1:0] start address, bits[6:ADDR_W] must be 0.
  - Bits are sampled on SPI_SCLK rising edges.
- State machine: IDLE -> CMD -> WDATA | RDATA | ERR.
  - IDLE: synchronized CSN falls -> CMD; bit counter=0, busy=1.
  - CMD: shift MOSI in on each rise. After the 8th rise:
    - nonzero reserved bits -> ERR, cmd_err pulses 1 cycle;
    - RW=0 -> WDATA;
    - RW=1 -> RDATA; fetch reg[addr] into the TX shifter.
  - WDATA: after each 8th rise, reg[addr] <= byte. reg_wr_pulse=1 on the next cycle with the addr/data just written; then addr advances.
  - RDATA: on each SPI_SCLK fall, drive the next TX bit on SPI_MISO.
    - The first fall after the command byte drives bit7 of reg[start].
    - The fall after the 8th data rise drives bit7 of the next register.
    - MOSI is ignored in this state.
  - ERR: no writes, SPI_MISO=0 until CSN rises.
- SPI_MISO is 0 in IDLE, CMD and ERR.
- Address wraps DEPTH-1 -> 0.
- Abort: synchronized CSN rising in any state -> IDLE next cycle, busy=0.
  - A partially received byte is discarded; no write and no strobe.
  - A write byte completed on the same cycle that CSN rises is still committed.
- CSN low with no SPI_SCLK edges: state holds indefinitely.
- rst_n low mid-frame: reset as above. After reset, the block stays in IDLE until synchronized CSN has been observed high, so a frame already in progress is ignored.
- Registers are written only via SPI; there is no other write path.

Optional Feature:
- Macro: SPI_SLAVE_AUTOINC_EN.
- Defined: address increments after every data byte (read or write) and wraps at DEPTH.
- Undefined: address is fixed for the whole frame. A write burst overwrites reg[start] repeatedly (one strobe per byte); a read burst returns reg[start] repeatedly.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE, CMD, WDATA, RDATA, ERR);
  - CMD_RW_BIT=7;
  - RW_READ=1'b1;
  - BYTE_W=8.
- One sub-module, spi_sync_edge: an N-stage synchronizer with rise/fall pulse outputs. It is instantiated for SPI_SCLK and SPI_CSN; MOSI uses a synchronizer only.

Test Plan:
- Reset then idle bus: all outputs 0; read of reg 3 returns 8'h00 (RESET_VAL).
- Write frame 8'h02, 8'hA5, 8'h3C: reg_wr_pulse twice, with (addr 2, A5) then (addr 3, 3C). A following read frame 8'h82 plus 2 dummy bytes returns A5, 3C on MISO.
- Write burst starting at addr 15 with data 11, 22: writes reg15=11 and reg0=22 (wrap). Without SPI_SLAVE_AUTOINC_EN, reg15 ends at 22 and reg0 is unchanged.
- Command 8'h40 with DEPTH=16: cmd_err pulses once; subsequent data byte 8'hFF is not written; MISO stays 0.
- CSN raised after 5 bits of a write data byte: no reg_wr_pulse and the register is unchanged. The next frame decodes normally.
- rst_n asserted mid-read frame: outputs reset the next cycle; remaining SCLK edges are ignored until CSN goes high; the next frame works.
